// File: rtl/vreg_pkg.sv
// Shared definitions for vector register file clients: geometry and sequencer states.
// No logic here; latency and backpressure are properties of the modules that import it.
package vreg_pkg;
    localparam int VREG_NREG  = 8;
    localparam int VREG_NELEM = 16;
    localparam int VREG_AW    = $clog2(VREG_NREG);
    localparam int VREG_IW    = $clog2(VREG_NELEM);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SER  = 2'd1,
        PAR  = 2'd2
    } state_t;
endpackage

// File: rtl/vreg_rr_arb.sv
// Two-requester round-robin arbiter; combinational grant, pointer updates on the granting edge.
// Grants only while en is high; a lone request always wins, a tie goes to the port not granted last.
module vreg_rr_arb (
    input  logic Clk,
    input  logic Rst_n,
    input  logic en,
    input  logic req_ser,
    input  logic req_par,
    output logic gnt_ser,
    output logic gnt_par
);
    logic last_ser;

    always_comb begin
        gnt_ser = 1'b0;
        gnt_par = 1'b0;
        if (en) begin
            if (req_ser && req_par) begin
                gnt_par = last_ser;
                gnt_ser = !last_ser;
            end else begin
                gnt_ser = req_ser;
                gnt_par = req_par;
            end
        end
    end

    // Reset value favours the parallel port on the first tie.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            last_ser <= 1'b1;
        end else if (gnt_ser) begin
            last_ser <= 1'b1;
        end else if (gnt_par) begin
            last_ser <= 1'b0;
        end
    end
endmodule

// File: rtl/vreg_ctrl.sv
// Vector register file sequencer: grant next cycle, serial op 16 beats, parallel op 1 cycle + done.
// Requests are held off (ignored) while Busy; no backpressure once an operation is in flight.
module vreg_ctrl
    import vreg_pkg::*;
#(
    parameter int NREG  = VREG_NREG,
    parameter int NELEM = VREG_NELEM
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     Ser_req,
    input  logic                     Ser_wr,
    input  logic [$clog2(NREG)-1:0]  Ser_addr,
    output logic                     Ser_gnt,
    output logic                     Ser_beat,
    output logic                     Ser_rvalid,
    output logic                     Ser_done,
    input  logic                     Par_req,
    input  logic                     Par_wr,
    input  logic [$clog2(NREG)-1:0]  Par_addr,
    input  logic [$clog2(NREG)-1:0]  Par_addr2,
    output logic                     Par_gnt,
    output logic                     Par_done,
    output logic                     RD_p,
    output logic                     WR_p,
    output logic                     RD_s,
    output logic                     WR_s,
    output logic [$clog2(NREG)-1:0]  Addr,
    output logic [$clog2(NREG)-1:0]  Addr2,
    output logic [$clog2(NELEM)-1:0] Sel,
    output logic                     Busy
);
    localparam int AW = $clog2(NREG);
    localparam int IW = $clog2(NELEM);

    state_t          state, state_nxt;
    logic            arb_ser, arb_par;
    logic            ser_wr_q, par_wr_q;
    logic [AW-1:0]   ser_addr_q, par_addr_q, par_addr2_q;
    logic [IW-1:0]   sel_q;
    logic            ser_gnt_q, par_gnt_q, par_done_q, ser_rvalid_q;
    logic            idle, last_beat;

    assign idle      = (state == IDLE);
    assign last_beat = (sel_q == IW'(NELEM - 1));

    vreg_rr_arb u_arb (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .en      (idle),
        .req_ser (Ser_req),
        .req_par (Par_req),
        .gnt_ser (arb_ser),
        .gnt_par (arb_par)
    );

    always_comb begin
        state_nxt = state;
        Ser_beat  = 1'b0;
        Ser_done  = 1'b0;
        RD_p      = 1'b0;
        WR_p      = 1'b0;
        RD_s      = 1'b0;
        WR_s      = 1'b0;
        Addr      = '0;
        Addr2     = '0;
        case (state)
            IDLE: begin
                if (arb_par) begin
                    state_nxt = PAR;
                end else if (arb_ser) begin
                    state_nxt = SER;
                end
            end
            SER: begin
                Ser_beat = 1'b1;
                WR_s     = ser_wr_q;
                RD_s     = !ser_wr_q;
                Addr     = ser_addr_q;
                if (last_beat) begin
                    Ser_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            PAR: begin
                WR_p      = par_wr_q;
                RD_p      = !par_wr_q;
                Addr      = par_addr_q;
                Addr2     = par_wr_q ? '0 : par_addr2_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state        <= IDLE;
            ser_gnt_q    <= 1'b0;
            par_gnt_q    <= 1'b0;
            par_done_q   <= 1'b0;
            ser_rvalid_q <= 1'b0;
            ser_wr_q     <= 1'b0;
            par_wr_q     <= 1'b0;
            ser_addr_q   <= '0;
            par_addr_q   <= '0;
            par_addr2_q  <= '0;
            sel_q        <= '0;
        end else begin
            state        <= state_nxt;
            ser_gnt_q    <= idle && arb_ser;
            par_gnt_q    <= idle && arb_par;
            par_done_q   <= (state == PAR);
            ser_rvalid_q <= Ser_beat && !ser_wr_q;
            if (idle && arb_ser) begin
                ser_wr_q   <= Ser_wr;
                ser_addr_q <= Ser_addr;
            end
            if (idle && arb_par) begin
                par_wr_q    <= Par_wr;
                par_addr_q  <= Par_addr;
                par_addr2_q <= Par_addr2;
            end
            // Beat counter only runs in SER and returns to 0 on exit, so every op starts at element 0.
            if (state == SER) begin
                sel_q <= last_beat ? '0 : sel_q + IW'(1);
            end else begin
                sel_q <= '0;
            end
        end
    end

    assign Ser_gnt    = ser_gnt_q;
    assign Par_gnt    = par_gnt_q;
    assign Par_done   = par_done_q;
    assign Ser_rvalid = ser_rvalid_q;
    assign Sel        = sel_q;
    assign Busy       = !idle;
endmodule

// File: tb/tb_vreg_ctrl.sv
// Scoreboard bench for vreg_ctrl: expected output vectors are queued with their cycle number.
// A negedge monitor pops one entry for every cycle in which any output is non-zero.
module tb_vreg_ctrl;
    import vreg_pkg::*;

    logic               Clk = 1'b0;
    logic               Rst_n = 1'b1;
    logic               Ser_req = 1'b0, Ser_wr = 1'b0;
    logic [VREG_AW-1:0] Ser_addr = '0;
    logic               Par_req = 1'b0, Par_wr = 1'b0;
    logic [VREG_AW-1:0] Par_addr = '0, Par_addr2 = '0;
    logic               Ser_gnt, Ser_beat, Ser_rvalid, Ser_done, Par_gnt, Par_done;
    logic               RD_p, WR_p, RD_s, WR_s, Busy;
    logic [VREG_AW-1:0] Addr, Addr2;
    logic [VREG_IW-1:0] Sel;

    typedef struct packed {
        logic               ser_gnt, ser_beat, ser_rvalid, ser_done, par_gnt, par_done;
        logic               rd_p, wr_p, rd_s, wr_s;
        logic [VREG_AW-1:0] addr, addr2;
        logic [VREG_IW-1:0] sel;
        logic               busy;
    } ovec_t;

    ovec_t act;
    int    cyc = 0;
    int    checks = 0, errors = 0;
    int    exp_cyc[$];
    ovec_t exp_vec[$];
    int    mon_ec;
    ovec_t mon_ev;

    vreg_ctrl dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .Ser_req(Ser_req), .Ser_wr(Ser_wr), .Ser_addr(Ser_addr),
        .Ser_gnt(Ser_gnt), .Ser_beat(Ser_beat), .Ser_rvalid(Ser_rvalid), .Ser_done(Ser_done),
        .Par_req(Par_req), .Par_wr(Par_wr), .Par_addr(Par_addr), .Par_addr2(Par_addr2),
        .Par_gnt(Par_gnt), .Par_done(Par_done),
        .RD_p(RD_p), .WR_p(WR_p), .RD_s(RD_s), .WR_s(WR_s),
        .Addr(Addr), .Addr2(Addr2), .Sel(Sel), .Busy(Busy)
    );

    assign act = {Ser_gnt, Ser_beat, Ser_rvalid, Ser_done, Par_gnt, Par_done,
                  RD_p, WR_p, RD_s, WR_s, Addr, Addr2, Sel, Busy};

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    function automatic void push(int c, ovec_t v);
        exp_cyc.push_back(c);
        exp_vec.push_back(v);
    endfunction

    // Request seen in IDLE cycle n: beats in n+1.., read data valid one cycle behind each beat.
    function automatic void push_ser(int n, logic wr, logic [VREG_AW-1:0] a, int beats);
        ovec_t v;
        for (int k = 0; k < beats; k++) begin
            v            = '0;
            v.ser_gnt    = (k == 0);
            v.ser_beat   = 1'b1;
            v.ser_rvalid = !wr && (k > 0);
            v.ser_done   = (k == 15);
            v.wr_s       = wr;
            v.rd_s       = !wr;
            v.addr       = a;
            v.sel        = VREG_IW'(k);
            v.busy       = 1'b1;
            push(n + 1 + k, v);
        end
        if (!wr && beats == 16) begin
            v            = '0;
            v.ser_rvalid = 1'b1;
            push(n + 17, v);
        end
    endfunction

    function automatic void push_par(int n, logic wr, logic [VREG_AW-1:0] a, logic [VREG_AW-1:0] a2);
        ovec_t v;
        v         = '0;
        v.par_gnt = 1'b1;
        v.wr_p    = wr;
        v.rd_p    = !wr;
        v.addr    = a;
        v.addr2   = wr ? '0 : a2;
        v.busy    = 1'b1;
        push(n + 1, v);
        v          = '0;
        v.par_done = 1'b1;
        push(n + 2, v);
    endfunction

    function automatic void chk(string name, ovec_t a, ovec_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, a, e);
        end
    endfunction

    task automatic step(int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    always @(negedge Clk) begin
        if (act != '0) begin
            checks++;
            if (exp_cyc.size() == 0) begin
                errors++;
                $display("FAIL mon_unexpected cyc=%0d got=%h want=idle", cyc, act);
            end else begin
                mon_ec = exp_cyc.pop_front();
                mon_ev = exp_vec.pop_front();
                if (mon_ec != cyc || mon_ev !== act) begin
                    errors++;
                    $display("FAIL mon cyc=%0d got=%h want_cyc=%0d want=%h", cyc, act, mon_ec, mon_ev);
                end
            end
        end
    end

    initial begin
        #1 Rst_n = 1'b0;
        step(3);
        chk("reset_outputs", act, '0);
        Rst_n = 1'b1;
        step(1);

        // Serial write to register 3
        Ser_req = 1'b1; Ser_wr = 1'b1; Ser_addr = 3'd3;
        push_ser(cyc, 1'b1, 3'd3, 16);
        step(1); Ser_req = 1'b0;
        step(20);

        // Parallel read of registers 2 and 5
        Par_req = 1'b1; Par_wr = 1'b0; Par_addr = 3'd2; Par_addr2 = 3'd5;
        push_par(cyc, 1'b0, 3'd2, 3'd5);
        step(1); Par_req = 1'b0;
        step(5);

        Rst_n = 1'b0;
        step(1);
        chk("reset_idle", act, '0);
        Rst_n = 1'b1;
        step(2);

        // Simultaneous requests from reset: parallel write first, then serial read of register 1
        Ser_req = 1'b1; Ser_wr = 1'b0; Ser_addr = 3'd1;
        Par_req = 1'b1; Par_wr = 1'b1; Par_addr = 3'd4; Par_addr2 = 3'd7;
        push_par(cyc, 1'b1, 3'd4, 3'd7);
        push_ser(cyc + 2, 1'b0, 3'd1, 16);
        step(1); Par_req = 1'b0;
        step(2); Ser_req = 1'b0;
        step(20);

        // Both held: grants alternate par, ser, par, ser
        Ser_req = 1'b1; Ser_wr = 1'b1; Ser_addr = 3'd5;
        Par_req = 1'b1; Par_wr = 1'b0; Par_addr = 3'd6; Par_addr2 = 3'd1;
        push_par(cyc, 1'b0, 3'd6, 3'd1);
        push_ser(cyc + 2, 1'b1, 3'd5, 16);
        push_par(cyc + 19, 1'b0, 3'd6, 3'd1);
        push_ser(cyc + 21, 1'b1, 3'd5, 16);
        step(22);
        Ser_req = 1'b0; Par_req = 1'b0;
        step(20);

        // Inputs change mid-stream; parallel request waits for the next IDLE cycle
        Ser_req = 1'b1; Ser_wr = 1'b1; Ser_addr = 3'd3;
        Par_wr = 1'b1; Par_addr = 3'd2; Par_addr2 = 3'd0;
        push_ser(cyc, 1'b1, 3'd3, 16);
        push_par(cyc + 17, 1'b1, 3'd2, 3'd0);
        step(1); Ser_req = 1'b0;
        step(4); Ser_addr = 3'd6; Ser_wr = 1'b0;
        step(3); Par_req = 1'b1;
        step(1); Par_req = 1'b0;
        step(3); Par_req = 1'b1;
        step(6); Par_req = 1'b0;
        step(5);

        // Reset at beat 7 of a serial write aborts without a done pulse
        Ser_req = 1'b1; Ser_wr = 1'b1; Ser_addr = 3'd2;
        push_ser(cyc, 1'b1, 3'd2, 7);
        step(1); Ser_req = 1'b0;
        step(7);
        Rst_n = 1'b0;
        #1;
        chk("abort_outputs", act, '0);
        step(2);
        chk("abort_hold", act, '0);
        Rst_n = 1'b1;
        step(2);

        Ser_req = 1'b1; Ser_wr = 1'b0; Ser_addr = 3'd7;
        push_ser(cyc, 1'b0, 3'd7, 16);
        step(1); Ser_req = 1'b0;
        step(22);

        while (exp_cyc.size() > 0) begin
            checks++;
            errors++;
            mon_ec = exp_cyc.pop_front();
            mon_ev = exp_vec.pop_front();
            $display("FAIL mon_missing got=none want_cyc=%0d want=%h", mon_ec, mon_ev);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vreg_ctrl.md
# vreg_ctrl

Sequencer and arbiter for the eight-entry, 16-element × 16-bit vector register file. It shares the register file between two requesters, a serial (element-at-a-time, memory side) port and a parallel (whole-vector, ALU side) port. It grants one operation at a time, latches its addresses, and drives the register file's command strobes, addresses and element index cycle by cycle. It sits between the vector load/store unit, the vector ALU and the register file.

## Interface
Parameters:
- NREG, 8, number of vector registers (address width = clog2(NREG))
- NELEM, 16, elements per vector (index width = clog2(NELEM))

Ports:
- Clk  in  1  single clock, all state on rising edge
- Rst_n  in  1  reset, asynchronous, active-low
- Ser_req  in  1  serial port request, held until Ser_gnt
- Ser_wr  in  1  1 = serial write (element stream into register), 0 = serial read
- Ser_addr  in  3  serial target register
- Ser_gnt  out  1  one-cycle grant pulse
- Ser_beat  out  1  high in each cycle an element command is issued
- Ser_rvalid  out  1  serial read data valid (Ser_beat of a read, delayed one cycle)
- Ser_done  out  1  one-cycle pulse with the last beat (index NELEM-1)
- Par_req  in  1  parallel port request, held until Par_gnt
- Par_wr  in  1  1 = parallel write, 0 = parallel read of two registers
- Par_addr  in  3  parallel register (write target / read operand A)
- Par_addr2  in  3  read operand B
- Par_gnt  out  1  one-cycle grant pulse
- Par_done  out  1  one-cycle pulse; for reads, register-file parallel outputs valid this cycle
- RD_p, WR_p, RD_s, WR_s  out  1 each  register-file command strobes, at most one high
- Addr, Addr2  out  3 each  register-file addresses
- Sel  out  4  element index for serial commands
- Busy  out  1  state != IDLE

## Operation
- States: IDLE, SER, PAR.
- IDLE: if exactly one request is high, grant it. If both are high, grant round-robin: the port not granted last wins. After reset, the last-granted pointer = serial, so parallel wins first.
- On grant (edge ending the IDLE cycle): latch wr/addr(s) into registers, pulse the matching *_gnt, reset Sel to 0, enter SER or PAR.
- SER: each cycle assert WR_s (Ser_wr=1) or RD_s (Ser_wr=0), Addr = latched Ser_addr, Sel = beat count, Ser_beat=1. Sel increments 0..NELEM-1. On Sel = NELEM-1, pulse Ser_done and return to IDLE.
- PAR: one cycle; assert WR_p or RD_p, Addr = latched Par_addr, Addr2 = latched Par_addr2 (Addr2 = 0 on writes); return to IDLE. Par_done pulses the following cycle.
- Ser_rvalid = Ser_beat && !wr, delayed one cycle (register-file read latency 1). Last read data is valid the cycle after Ser_done.
- Requests are ignored while Busy. Input changes after grant have no effect on the operation in flight.
- Write data does not pass through this block; the serial requester advances its data on Ser_beat and the parallel requester holds DataIn_p during PAR.

## Timing
- Reset (async assert, sync-deasserted use): state IDLE, every output 0, Sel 0, Addr/Addr2 0, pointer = serial.
- Reset mid-operation aborts immediately: strobes drop with Rst_n low, and no done pulse is issued.
- Grant latency: request seen in IDLE cycle N → *_gnt high in cycle N+1, first command in cycle N+1.
- Serial op: commands cycles N+1..N+16, Ser_done in N+16, IDLE in N+17. Reads: Ser_rvalid N+2..N+17.
- Parallel op: command in N+1, Par_done in N+2, IDLE in N+2.
- Minimum one IDLE cycle between operations. Back-to-back serial ops complete every 17 cycles.
- Sel is 4-bit, wraps only by state exit, never by overflow.

## Structure
- Shared package vreg_pkg: state enum (IDLE/SER/PAR), NREG/NELEM constants, address/index width constants. Reuse them in any other register-file clients.
- One natural sub-module: vreg_rr_arb, a 2-requester round-robin arbiter with a last-grant pointer.
- Keep the beat counter and done/rvalid delay registers in the top.

## Test plan
- Reset then Ser_req=1, Ser_wr=1, Ser_addr=3 → Ser_gnt at N+1; WR_s high 16 cycles, Addr=3, Sel 0..15; Ser_done with Sel=15; Busy low at N+17.
- Par_req=1, Par_wr=0, Par_addr=2, Par_addr2=5 → RD_p one cycle with Addr=2, Addr2=5; Par_done next cycle; no serial strobe ever high.
- Ser_req and Par_req rise together from reset → parallel granted first, serial granted at the next IDLE. Repeat with both held → grants alternate.
- Serial read of register 1 → Ser_rvalid 16 cycles, offset +1 from Ser_beat; last one the cycle after Ser_done.
- Change Ser_addr from 3 to 6 mid-stream, and pulse Par_req during SER → Addr stays 3, no Par_gnt until after Ser_done+1.
- Drop Rst_n at beat 7 of a serial write → all strobes and Busy 0 immediately, no Ser_done; after release a fresh request restarts at Sel=0.
